mac_operand_arbiter: RTL and testbench
======================================

Name: mac_operand_arbiter

Overview:
- Shares one 64-bit ready/valid operand channel into the systolic MAC array between NUM_REQ upstream sources, e.g. weight loader, activation loader and host debug port.
- Uses round-robin arbitration.
- Accepts one beat from the granted source into an output holding register.
- Presents that beat downstream with the source ID until the consumer accepts it.
- Sustains one beat per cycle under continuous demand.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 64, beat width in bits.
- SRC_W, $clog2(NUM_REQ), width of source ID.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester valid.
- req_data  input  NUM_REQ*DATA_W  per-requester data; requester i at bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  per-requester accept strobe, one-hot or zero.
- out_valid  output  1  holding register contains a beat.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_W  held beat.
- out_src  output  SRC_W  index of the requester that supplied out_data.
- busy  output  1  equals out_valid; status for the array sequencer.

Behaviour:
- Reset: reset is asynchronous, active-high. Clock is clk.
  - While reset is high: state=IDLE, rr_ptr=0, out_valid=0, out_data=0, out_src=0, busy=0, req_ready=0.
  - Asserting reset mid-transfer discards the held beat immediately.
  - No beat is accepted in the cycle reset deasserts unless the normal rules below apply on the following edge.
- States:
  - IDLE: holding register empty.
  - HOLD: holding register full.
- Grant selection (combinational):
  - g = first index i, scanning rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ, with req_valid[i]=1.
  - If no req_valid bit is set, there is no grant.
- Accept condition:
  - accept = (any req_valid) && (state==IDLE || (state==HOLD && out_ready)).
  - req_ready[g] = accept; all other req_ready bits are 0.
  - req_ready depends on req_valid; requesters must not make valid depend on ready.
- On an accept edge:
  - out_data <= req_data[g], out_src <= g, out_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Next state is HOLD.
- In HOLD with out_ready=1 and no req_valid: out_valid <= 0, next state IDLE, out_data and out_src keep their last values.
- In HOLD with out_ready=0:
  - Stay in HOLD; out_data and out_src stay stable; all req_ready=0.
  - Requesters hold valid and data stable (no retraction).
- Latency: a beat accepted at edge k is visible on out_* after edge k. Throughput is 1 beat/cycle when out_ready stays high.
- Fairness: a requester holding valid high is granted within NUM_REQ accepts. rr_ptr advances only on accept.
- rr_ptr wraps from NUM_REQ-1 to 0. Non-power-of-2 NUM_REQ must wrap correctly, e.g. 3 -> 0,1,2,0.
- Simultaneous events in HOLD with out_ready=1 and a pending request: downstream transfer and new accept occur on the same edge. out_valid stays 1 with no bubble.
- Illegal states fall back to IDLE.

Test Plan:
- Reset: assert reset mid-HOLD with out_data=64'hDEAD_BEEF_0000_0001 -> out_valid=0, out_data=0, out_src=0 and req_ready=0 immediately (asynchronous), without waiting for a clock edge.
- Single requester: req_valid=4'b0100, req_data[2]=64'h1234 -> req_ready=4'b0100 for exactly one cycle. Next cycle: out_valid=1, out_data=64'h1234, out_src=2, rr_ptr=3.
- All requesters: req_valid=4'b1111 held high, out_ready=1, data = index -> grants in order 0,1,2,3,0,1. out_valid continuously 1, one beat per cycle, no bubbles.
- Backpressure: while in HOLD with out_src=1, hold out_ready=0 for 5 cycles with req_valid=4'b1101 -> out_data/out_src stable and req_ready=0 throughout. On out_ready=1, requester 2 is granted (scan starts at rr_ptr=2, picks 2).
- Drain to IDLE: single beat, then req_valid=0 with out_ready=1 -> out_valid falls after one edge. State is IDLE and busy=0.
- Wrap with NUM_REQ=3: requests from 2 then 0 -> rr_ptr goes 0 -> 0 (after g=2, ptr=(2+1) mod 3=0) -> 1, out_src sequence 2,0.

Source files
------------

// File: rtl/mac_operand_arbiter.sv
// rtl/mac_operand_arbiter.sv - round-robin arbiter sharing one held 64-bit operand channel into the MAC array
module mac_operand_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    output logic                      busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  grant;
    logic [SRC_W-1:0]  cand;
    logic [SRC_W-1:0]  ptr_nxt;
    logic              found;
    logic              accept;
    logic [DATA_W-1:0] req_words [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_words[i] = req_data[i*DATA_W +: DATA_W];
    end

    // Scan from rr_ptr upward with modulo wrap so non-power-of-2 NUM_REQ never selects a missing index.
    always_comb begin
        grant = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    // Gated by reset so no requester sees a strobe while the holding register is being cleared.
    assign accept  = found && !reset && (state == IDLE || out_ready);
    assign ptr_nxt = (grant == SRC_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    state_nxt = HOLD;
                end else if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            out_data <= '0;
            out_src  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                out_data <= req_words[grant];
                out_src  <= grant;
                rr_ptr   <= ptr_nxt;
            end
        end
    end

    assign out_valid = (state == HOLD);
    assign busy      = out_valid;

endmodule

// File: tb/tb_mac_operand_arbiter.sv
// tb/tb_mac_operand_arbiter.sv - scoreboard bench for mac_operand_arbiter (NUM_REQ=4 and NUM_REQ=3)
module tb_mac_operand_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [63:0] data_w [4];
    logic [255:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [1:0]  out_src;
    logic        busy;

    logic        reset3 = 1'b1;
    logic [2:0]  req_valid3 = '0;
    logic [63:0] data3 [3];
    logic [191:0] req_data3;
    logic [2:0]  req_ready3;
    logic        out_valid3;
    logic        out_ready3 = 1'b0;
    logic [63:0] out_data3;
    logic [1:0]  out_src3;
    logic        busy3;

    int vectors = 0;
    int miscompares = 0;

    always_comb req_data  = {data_w[3], data_w[2], data_w[1], data_w[0]};
    always_comb req_data3 = {data3[2], data3[1], data3[0]};

    mac_operand_arbiter #(.NUM_REQ(4), .DATA_W(64)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src), .busy(busy)
    );

    mac_operand_arbiter #(.NUM_REQ(3), .DATA_W(64)) dut3 (
        .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_data(req_data3),
        .req_ready(req_ready3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_data(out_data3), .out_src(out_src3), .busy(busy3)
    );

    // Reference model of the 4-requester instance, evaluated mid-cycle while inputs are stable.
    logic [65:0] sb [$];
    logic [65:0] sb_exp;
    int          m_ptr = 0;
    int          m_g;
    bit          m_full = 1'b0;
    bit          m_acc;
    logic [3:0]  m_exp;

    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            m_full = 1'b0;
            m_ptr  = 0;
        end else begin
            m_g = -1;
            for (int k = 0; k < 4; k++) begin
                if (m_g < 0 && req_valid[(m_ptr + k) % 4]) m_g = (m_ptr + k) % 4;
            end
            m_acc = (m_g >= 0) && (!m_full || out_ready);
            m_exp = m_acc ? (4'b0001 << m_g) : 4'b0000;
            vectors++;
            if (req_ready !== m_exp) begin
                miscompares++;
                $display("FAIL sb_req_ready: got %b expected %b at %0t", req_ready, m_exp, $time);
            end
            vectors++;
            if (out_valid !== m_full || busy !== m_full) begin
                miscompares++;
                $display("FAIL sb_out_valid: got %b/%b expected %b at %0t", out_valid, busy, m_full, $time);
            end
            if (m_full && out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_underflow: got beat src=%0d data=%h expected none at %0t", out_src, out_data, $time);
                end else begin
                    sb_exp = sb.pop_front();
                    if ({out_src, out_data} !== sb_exp) begin
                        miscompares++;
                        $display("FAIL sb_beat: got %h expected %h at %0t", {out_src, out_data}, sb_exp, $time);
                    end
                end
            end
            if (m_acc) begin
                sb.push_back({2'(m_g), data_w[m_g]});
                m_ptr  = (m_g + 1) % 4;
                m_full = 1'b1;
            end else if (out_ready) begin
                m_full = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) data_w[i] = 64'h0;
        req_valid = 4'b1111;
        step();
        step();
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 64'h0 || out_src !== 2'd0 || req_ready !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b b=%b d=%h s=%0d r=%b expected all zero", out_valid, busy, out_data, out_src, req_ready);
        end
        reset = 1'b0;
        req_valid = 4'b0000;
        data_w[0] = 64'hDEAD_BEEF_0000_0001;
        req_valid = 4'b0001;
        out_ready = 1'b0;
        step();
        req_valid = 4'b0000;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 64'hDEAD_BEEF_0000_0001) begin
            miscompares++;
            $display("FAIL reset_pre_hold: got v=%b d=%h expected 1 deadbeef00000001", out_valid, out_data);
        end
        #2;
        reset = 1'b1;
        req_valid = 4'b1111;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 64'h0 || out_src !== 2'd0 || req_ready !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_async: got v=%b b=%b d=%h s=%0d r=%b expected all zero", out_valid, busy, out_data, out_src, req_ready);
        end
        step();
        req_valid = 4'b0000;
        reset = 1'b0;
    endtask

    task automatic test_single();
        out_ready = 1'b0;
        data_w[2] = 64'h1234;
        req_valid = 4'b0100;
        #1;
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_ready: got %b expected 0100", req_ready);
        end
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 64'h1234 || out_src !== 2'd2 || req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_out: got v=%b d=%h s=%0d r=%b expected 1 1234 2 0000", out_valid, out_data, out_src, req_ready);
        end
        data_w[3] = 64'h3333;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL single_ptr3: got %b expected 1000", req_ready);
        end
        step();
        req_valid = 4'b0000;
        vectors++;
        if (out_src !== 2'd3 || out_data !== 64'h3333) begin
            miscompares++;
            $display("FAIL single_next: got s=%0d d=%h expected 3 3333", out_src, out_data);
        end
        step();
    endtask

    task automatic test_all();
        int ord [6] = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < 4; i++) data_w[i] = 64'(i);
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            #1;
            vectors++;
            if (req_ready !== (4'b0001 << ord[n])) begin
                miscompares++;
                $display("FAIL all_grant%0d: got %b expected %b", n, req_ready, 4'b0001 << ord[n]);
            end
            step();
            vectors++;
            if (out_valid !== 1'b1 || out_src !== 2'(ord[n]) || out_data !== 64'(ord[n])) begin
                miscompares++;
                $display("FAIL all_beat%0d: got v=%b s=%0d d=%h expected 1 %0d", n, out_valid, out_src, out_data, ord[n]);
            end
        end
        req_valid = 4'b0000;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        data_w[0] = 64'hA0;
        data_w[2] = 64'hA2;
        data_w[3] = 64'hA3;
        req_valid = 4'b1101;
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            #1;
            vectors++;
            if (req_ready !== 4'b0000 || out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 64'h1) begin
                miscompares++;
                $display("FAIL bp_stall%0d: got r=%b v=%b s=%0d d=%h expected 0000 1 1 1", n, req_ready, out_valid, out_src, out_data);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL bp_release: got %b expected 0100", req_ready);
        end
        step();
        vectors++;
        if (out_src !== 2'd2 || out_data !== 64'hA2) begin
            miscompares++;
            $display("FAIL bp_beat: got s=%0d d=%h expected 2 a2", out_src, out_data);
        end
        req_valid = 4'b1001;
        #1;
        vectors++;
        if (req_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL bp_next3: got %b expected 1000", req_ready);
        end
        step();
        req_valid = 4'b0001;
        #1;
        vectors++;
        if (req_ready !== 4'b0001 || out_src !== 2'd3) begin
            miscompares++;
            $display("FAIL bp_next0: got r=%b s=%0d expected 0001 3", req_ready, out_src);
        end
        step();
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_drain();
        data_w[0] = 64'hD0;
        req_valid = 4'b0001;
        out_ready = 1'b1;
        step();
        req_valid = 4'b0000;
        vectors++;
        if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 64'hD0) begin
            miscompares++;
            $display("FAIL drain_beat: got v=%b s=%0d d=%h expected 1 0 d0", out_valid, out_src, out_data);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0 || out_data !== 64'hD0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_idle: got v=%b b=%b r=%b d=%h q=%0d expected 0 0 0000 d0 0", out_valid, busy, req_ready, out_data, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] acc;
        acc = 4'b0000;
        for (int n = 0; n < 300; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    data_w[i] = {$urandom, $urandom};
                end
            end
            #1;
            acc = req_ready;
            step();
        end
        req_valid = 4'b0000;
        out_ready = 1'b1;
        step();
        step();
        vectors++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_drain: got v=%b q=%0d expected 0 0", out_valid, sb.size());
        end
    endtask

    task automatic test_wrap_3();
        reset3 = 1'b0;
        for (int i = 0; i < 3; i++) data3[i] = 64'h300 + 64'(i);
        out_ready3 = 1'b1;
        req_valid3 = 3'b100;
        #1;
        vectors++;
        if (req_ready3 !== 3'b100) begin
            miscompares++;
            $display("FAIL wrap3_g2: got %b expected 100", req_ready3);
        end
        step();
        req_valid3 = 3'b001;
        #1;
        vectors++;
        if (out_src3 !== 2'd2 || out_data3 !== 64'h302 || req_ready3 !== 3'b001) begin
            miscompares++;
            $display("FAIL wrap3_g0: got s=%0d d=%h r=%b expected 2 302 001", out_src3, out_data3, req_ready3);
        end
        step();
        req_valid3 = 3'b111;
        #1;
        vectors++;
        if (out_src3 !== 2'd0 || out_data3 !== 64'h300 || req_ready3 !== 3'b010) begin
            miscompares++;
            $display("FAIL wrap3_ptr1: got s=%0d d=%h r=%b expected 0 300 010", out_src3, out_data3, req_ready3);
        end
        step();
        req_valid3 = 3'b000;
        vectors++;
        if (out_src3 !== 2'd1 || out_valid3 !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap3_g1: got s=%0d v=%b expected 1 1", out_src3, out_valid3);
        end
        step();
        vectors++;
        if (out_valid3 !== 1'b0 || busy3 !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap3_idle: got v=%b b=%b expected 0 0", out_valid3, busy3);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) data3[i] = 64'h0;
        test_reset();
        test_single();
        test_all();
        test_backpressure();
        test_drain();
        test_back_to_back();
        test_wrap_3();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
